// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment display path: default parameters
// and the hex-to-segment encoding table (bit0 = a ... bit6 = g).
package seg_pkg;

  localparam int DEF_NB_DIGITS   = 4;
  localparam int DEF_SLOT_CYCLES = 1000;
  localparam int DEF_BRIGHT_W    = 4;
  localparam int DEF_COLON_DIGIT = 1;
  localparam int DEF_ACTIVE_LOW  = 0;

  // Entry 15 is leftmost, entry 0 rightmost.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    return SEG_TABLE[nib];
  endfunction

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational hex nibble to active-high seven-segment pattern.
module seg_hex_decoder
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segs
);

  assign segs = hex_to_seg(nibble);

endmodule

// File: rtl/seven_seg_mux.sv
// Time-multiplexed seven-segment driver with frame-synchronous display
// updates, PWM brightness and optional active-low pins.
module seven_seg_mux
  import seg_pkg::*;
#(
  parameter int NB_DIGITS   = DEF_NB_DIGITS,
  parameter int SLOT_CYCLES = DEF_SLOT_CYCLES,
  parameter int BRIGHT_W    = DEF_BRIGHT_W,
  parameter int COLON_DIGIT = DEF_COLON_DIGIT,
  parameter int ACTIVE_LOW  = DEF_ACTIVE_LOW
) (
  input  logic                   clk,
  input  logic                   reset_in,
  input  logic [4*NB_DIGITS-1:0] digits,
  input  logic [NB_DIGITS-1:0]   dots,
  input  logic [NB_DIGITS-1:0]   blank,
  input  logic                   colon,
  input  logic [BRIGHT_W-1:0]    brightness,
  input  logic                   load,
  output logic [6:0]             segments,
  output logic [NB_DIGITS-1:0]   seg_select,
  output logic                   seg_colon,
  output logic                   seg_dot,
  output logic                   frame_start
);

  localparam int   IDX_W = (NB_DIGITS > 1) ? $clog2(NB_DIGITS) : 1;
  localparam int   PRE_W = $clog2(SLOT_CYCLES);
  localparam logic INV   = (ACTIVE_LOW != 0);

  logic [PRE_W-1:0]       presc_reg, presc_next;
  logic [IDX_W-1:0]       index_reg, index_next;
  logic [BRIGHT_W-1:0]    pwm_reg;

  logic [4*NB_DIGITS-1:0] pend_digits_reg, pend_digits_next, act_digits_reg;
  logic [NB_DIGITS-1:0]   pend_dots_reg, pend_dots_next, act_dots_reg;
  logic [NB_DIGITS-1:0]   pend_blank_reg, pend_blank_next, act_blank_reg;
  logic                   pend_colon_reg, pend_colon_next, act_colon_reg;
  logic [BRIGHT_W-1:0]    pend_bright_reg, pend_bright_next, act_bright_reg;

  logic [6:0]             segments_reg;
  logic [NB_DIGITS-1:0]   seg_select_reg;
  logic                   seg_colon_reg, seg_dot_reg, frame_start_reg;

  logic                   slot_end, last_digit, boundary;
  logic                   digit_on, visible;
  logic [NB_DIGITS-1:0]   sel_onehot;
  logic [3:0]             nibble_arr [NB_DIGITS];
  logic [3:0]             cur_nibble;
  logic [6:0]             dec_segs;

  assign slot_end   = (presc_reg == PRE_W'(SLOT_CYCLES - 1));
  assign last_digit = (index_reg == IDX_W'(NB_DIGITS - 1));
  assign boundary   = slot_end && last_digit;

  assign presc_next = slot_end ? '0 : presc_reg + PRE_W'(1);
  assign index_next = !slot_end  ? index_reg :
                      last_digit ? '0 : index_reg + IDX_W'(1);

  // A load on the boundary cycle bypasses pending straight into active.
  assign pend_digits_next = load ? digits     : pend_digits_reg;
  assign pend_dots_next   = load ? dots       : pend_dots_reg;
  assign pend_blank_next  = load ? blank      : pend_blank_reg;
  assign pend_colon_next  = load ? colon      : pend_colon_reg;
  assign pend_bright_next = load ? brightness : pend_bright_reg;

  for (genvar gi = 0; gi < NB_DIGITS; gi++) begin : g_digit
    assign nibble_arr[gi] = act_digits_reg[4*gi +: 4];
    assign sel_onehot[gi] = (index_reg == IDX_W'(gi));
  end

  assign cur_nibble = nibble_arr[index_reg];

  seg_hex_decoder u_dec (
    .nibble (cur_nibble),
    .segs   (dec_segs)
  );

  assign digit_on = (&act_bright_reg) || (pwm_reg < act_bright_reg);
  assign visible  = digit_on && !act_blank_reg[index_reg];

  // Output registers hold pin-level values so inversion costs no extra stage.
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      presc_reg       <= '0;
      index_reg       <= '0;
      pwm_reg         <= '0;
      pend_digits_reg <= '0;
      pend_dots_reg   <= '0;
      pend_blank_reg  <= '0;
      pend_colon_reg  <= 1'b0;
      pend_bright_reg <= '0;
      act_digits_reg  <= '0;
      act_dots_reg    <= '0;
      act_blank_reg   <= '0;
      act_colon_reg   <= 1'b0;
      act_bright_reg  <= '0;
      segments_reg    <= {7{INV}};
      seg_select_reg  <= {NB_DIGITS{INV}};
      seg_colon_reg   <= INV;
      seg_dot_reg     <= INV;
      frame_start_reg <= 1'b0;
    end else begin
      presc_reg       <= presc_next;
      index_reg       <= index_next;
      pwm_reg         <= pwm_reg + BRIGHT_W'(1);
      pend_digits_reg <= pend_digits_next;
      pend_dots_reg   <= pend_dots_next;
      pend_blank_reg  <= pend_blank_next;
      pend_colon_reg  <= pend_colon_next;
      pend_bright_reg <= pend_bright_next;
      if (boundary) begin
        act_digits_reg <= pend_digits_next;
        act_dots_reg   <= pend_dots_next;
        act_blank_reg  <= pend_blank_next;
        act_colon_reg  <= pend_colon_next;
        act_bright_reg <= pend_bright_next;
      end
      segments_reg    <= (visible ? dec_segs : 7'd0) ^ {7{INV}};
      seg_select_reg  <= (visible ? sel_onehot : '0) ^ {NB_DIGITS{INV}};
      seg_dot_reg     <= (visible && act_dots_reg[index_reg]) ^ INV;
      seg_colon_reg   <= (visible && act_colon_reg &&
                          (index_reg == IDX_W'(COLON_DIGIT))) ^ INV;
      frame_start_reg <= (presc_reg == '0) && (index_reg == '0);
    end
  end

  assign segments    = segments_reg;
  assign seg_select  = seg_select_reg;
  assign seg_colon   = seg_colon_reg;
  assign seg_dot     = seg_dot_reg;
  assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_seven_seg_mux.sv
// Randomized bench for seven_seg_mux: a cycle-indexed arithmetic model predicts
// every output of an active-high and an active-low instance.
module tb_seven_seg_mux;

  localparam int NB    = 4;
  localparam int SC    = 4;
  localparam int FRAME = NB * SC;

  typedef struct packed {
    logic [15:0] digits;
    logic [3:0]  dots;
    logic [3:0]  blank;
    logic        colon;
    logic [3:0]  bright;
  } cfg_t;

  logic       clk = 1'b0;
  logic       reset_in;
  logic       load;
  cfg_t       drv;

  logic [6:0] segments, segments_i;
  logic [3:0] seg_select, seg_select_i;
  logic       seg_colon, seg_colon_i, seg_dot, seg_dot_i, frame_start, frame_start_i;

  int n_checks = 0;
  int n_errors = 0;
  int t = 0;
  int sel_cnt = 0;
  cfg_t m_act, m_pend;

  logic [6:0] seg_ref [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  always #5 clk = ~clk;

  seven_seg_mux #(.NB_DIGITS(NB), .SLOT_CYCLES(SC), .BRIGHT_W(4), .COLON_DIGIT(1),
                  .ACTIVE_LOW(0)) dut (
    .clk(clk), .reset_in(reset_in), .digits(drv.digits), .dots(drv.dots),
    .blank(drv.blank), .colon(drv.colon), .brightness(drv.bright), .load(load),
    .segments(segments), .seg_select(seg_select), .seg_colon(seg_colon),
    .seg_dot(seg_dot), .frame_start(frame_start));

  seven_seg_mux #(.NB_DIGITS(NB), .SLOT_CYCLES(SC), .BRIGHT_W(4), .COLON_DIGIT(1),
                  .ACTIVE_LOW(1)) dut_inv (
    .clk(clk), .reset_in(reset_in), .digits(drv.digits), .dots(drv.dots),
    .blank(drv.blank), .colon(drv.colon), .brightness(drv.bright), .load(load),
    .segments(segments_i), .seg_select(seg_select_i), .seg_colon(seg_colon_i),
    .seg_dot(seg_dot_i), .frame_start(frame_start_i));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected {frame_start, colon, dot, select[3:0], segments[6:0]} for edge t.
  function automatic logic [13:0] model_out();
    int idx = (t / SC) % NB;
    int pwm = t % 16;
    logic vis;
    logic [6:0] s;
    logic [3:0] sel;
    logic [3:0] nib;
    vis = ((m_act.bright == 4'hF) || (pwm < int'(m_act.bright))) && !m_act.blank[idx];
    nib = m_act.digits[idx*4 +: 4];
    s   = vis ? seg_ref[nib] : 7'd0;
    sel = vis ? 4'(1 << idx) : 4'd0;
    return {(t % FRAME) == 0, vis && m_act.colon && (idx == 1),
            vis && m_act.dots[idx], sel, s};
  endfunction

  task automatic step();
    logic [13:0] exp_v;
    @(posedge clk);
    #1;
    exp_v = model_out();
    check_eq($sformatf("out t=%0d", t),
             {18'd0, frame_start, seg_colon, seg_dot, seg_select, segments}, {18'd0, exp_v});
    check_eq($sformatf("inv t=%0d", t),
             {18'd0, frame_start_i, seg_colon_i, seg_dot_i, seg_select_i, segments_i},
             {18'd0, exp_v[13], ~exp_v[12:0]});
    if (seg_select != 4'd0) sel_cnt++;
    if (load) m_pend = drv;
    if ((t % FRAME) == FRAME - 1) m_act = m_pend;
    t++;
  endtask

  task automatic do_load(input cfg_t c);
    $display("load t=%0d digits=%h bright=%0d blank=%b dots=%b colon=%b",
             t, c.digits, c.bright, c.blank, c.dots, c.colon);
    drv  = c;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic wait_phase(input int p);
    while ((t % FRAME) != p) step();
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_hi"}, {18'd0, frame_start, seg_colon, seg_dot, seg_select, segments}, 32'd0);
    check_eq({tag, "_lo"}, {18'd0, frame_start_i, seg_colon_i, seg_dot_i, seg_select_i, segments_i},
             {18'd0, 1'b0, 13'h1FFF});
  endtask

  task automatic model_reset();
    t      = 0;
    m_act  = '0;
    m_pend = '0;
  endtask

  initial begin
    cfg_t c;
    reset_in = 1'b0;
    load     = 1'b0;
    drv      = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    @(negedge clk);
    reset_in = 1'b1;

    // Dark after reset until a load lands at a boundary.
    repeat (3) step();
    c = '{digits: 16'h1234, dots: 4'b0, blank: 4'b0, colon: 1'b0, bright: 4'hF};
    do_load(c);
    repeat (2 * FRAME + 4) step();

    // Mid-frame load: rest of this frame keeps old digits.
    wait_phase(6);
    c.digits = 16'hABCD;
    do_load(c);
    repeat (FRAME + 8) step();

    // Partial brightness: 4 of every 16 cycles lit.
    c.bright = 4'd4;
    do_load(c);
    wait_phase(0);
    sel_cnt = 0;
    repeat (16) step();
    check_eq("bright4_cnt", sel_cnt, 4);
    c.bright = 4'd0;
    do_load(c);
    wait_phase(0);
    sel_cnt = 0;
    repeat (16) step();
    check_eq("bright0_cnt", sel_cnt, 0);

    // Blank, colon and dot gating.
    c = '{digits: 16'h5678, dots: 4'b0001, blank: 4'b0100, colon: 1'b1, bright: 4'hF};
    do_load(c);
    repeat (2 * FRAME) step();

    // Load coincident with the frame boundary.
    wait_phase(FRAME - 1);
    c.digits = 16'h9E0F;
    c.blank  = 4'b0;
    do_load(c);
    repeat (FRAME) step();

    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 20)) step();
      c.digits = 16'($urandom);
      c.dots   = 4'($urandom);
      c.blank  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0;
      c.colon  = 1'($urandom);
      c.bright = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
      do_load(c);
    end
    repeat (2 * FRAME) step();

    // Reset mid-slot with a pending load that must be discarded.
    wait_phase(2);
    c = '{digits: 16'h8888, dots: 4'hF, blank: 4'b0, colon: 1'b1, bright: 4'hF};
    do_load(c);
    @(posedge clk);
    #3;
    reset_in = 1'b0;
    #1;
    check_reset_state("mid_reset");
    model_reset();
    repeat (2) @(negedge clk);
    reset_in = 1'b1;
    step();
    check_eq("fs_first_edge", {31'd0, frame_start}, 32'd1);
    repeat (3 * FRAME) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/seven_seg_mux.md
SEVEN_SEG_MUX -- requirements
Module: seven_seg_mux

Interface
REQ-001 SHALL have parameter NB_DIGITS, default 4: number of multiplexed digits (1..8).
REQ-002 SHALL have parameter SLOT_CYCLES, default 1000: clk cycles each digit is selected (>=2).
REQ-003 SHALL have parameter BRIGHT_W, default 4: brightness field width.
REQ-004 SHALL have parameter COLON_DIGIT, default 1: digit slot during which seg_colon may assert.
REQ-005 SHALL have parameter ACTIVE_LOW, default 0: when 1, segments, seg_select, seg_colon and seg_dot are all inverted at the pins.
REQ-006 SHALL have port clk  in  1  system clock, sole clock.
REQ-007 SHALL have port reset_in  in  1  asynchronous, active-low reset.
REQ-008 SHALL have port digits  in  4*NB_DIGITS  hex nibble per digit, digit 0 in LSBs.
REQ-009 SHALL have port dots  in  NB_DIGITS  decimal point per digit.
REQ-010 SHALL have port blank  in  NB_DIGITS  1 = digit never selected.
REQ-011 SHALL have port colon  in  1  colon request.
REQ-012 SHALL have port brightness  in  BRIGHT_W  0 = off, all-ones = full on.
REQ-013 SHALL have port load  in  1  single-cycle strobe capturing digits/dots/blank/colon/brightness.
REQ-014 SHALL have port segments  out  7  bit0 = a ... bit6 = g.
REQ-015 SHALL have port seg_select  out  NB_DIGITS  one-hot digit enable.
REQ-016 SHALL have ports seg_colon, seg_dot  out  1 each; and frame_start  out  1  one-cycle pulse on entering digit 0.

Function
REQ-017 SHALL hold inputs in a pending register on load; a later load before the frame boundary overwrites pending.
REQ-018 SHALL copy pending to the active register only at a frame boundary (digit index wraps NB_DIGITS-1 -> 0); load coincident with the boundary SHALL make that cycle's inputs active.
REQ-019 SHALL count slot prescaler 0..SLOT_CYCLES-1; at SLOT_CYCLES-1 it wraps to 0 and digit index increments, NB_DIGITS-1 wrapping to 0.
REQ-020 SHALL pulse frame_start for exactly one cycle in the first cycle of digit 0's slot.
REQ-021 SHALL drive a free-running BRIGHT_W-bit pwm counter; a digit is "on" when brightness is all-ones or pwm counter < brightness.
REQ-022 SHALL drive seg_select one-hot at current index only when digit on and not blanked, else all inactive.
REQ-023 SHALL decode active nibble: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71 (hex); segments inactive when digit off or blanked.
REQ-024 SHALL assert seg_dot with dots[index] and seg_colon with colon only when index == COLON_DIGIT, both gated like seg_select.
REQ-025 SHALL register all outputs; output reflects index/prescaler/pwm state with exactly 1 cycle latency.
REQ-026 SHALL leave blanked slots in the rotation (slot time preserved, frame period = NB_DIGITS*SLOT_CYCLES).

Reset
REQ-027 SHALL on reset_in low immediately force prescaler, index, pwm counter, pending and active registers to 0 and all outputs inactive (pin level per ACTIVE_LOW), frame_start 0.
REQ-028 SHALL after release start digit 0's slot, asserting frame_start on the first clk edge; active brightness 0 keeps display dark until a load is applied.
REQ-029 SHALL discard a pending load on reset mid-frame.

Structure
REQ-030 SHALL place the 16 segment encodings and default parameter constants in shared package seg_pkg.
REQ-031 SHALL instantiate one combinational sub-module seg_hex_decoder (4-bit in, 7-bit out); counters, registers and gating stay in seven_seg_mux.

Verification
REQ-032 SHALL cover: NB_DIGITS=4, SLOT_CYCLES=4, load digits=16'h1234, brightness=F -> after boundary, select cycles 0001,0010,0100,1000 with segments 66,4F,5B,06 (digit 0 = 4), frame_start every 16 cycles.
REQ-033 SHALL cover: load mid-frame with digits=16'hABCD -> remaining slots of current frame show old values, next frame shows 5E,39,7C,77.
REQ-034 SHALL cover: brightness=4 (BRIGHT_W=4) -> seg_select active 4 of each 16 cycles; brightness=0 -> never active.
REQ-035 SHALL cover: blank=4'b0100, colon=1, dots=4'b0001 -> slot 2 dark but 4-cycle slot kept; seg_colon only in slot 1; seg_dot only in slot 0.
REQ-036 SHALL cover: ACTIVE_LOW=1 -> all outputs exact complements of ACTIVE_LOW=0 run; reset_in low mid-slot -> outputs inactive same cycle, pending discarded, frame_start on first edge after release.
